// File: rtl/store_buffer_if.sv
// rtl/store_buffer_if.sv - commit, load-forwarding and data-cache signal bundle for the store buffer
interface store_buffer_if;
    logic        enq_valid;
    logic [31:0] enq_addr;
    logic [31:0] enq_wdata;
    logic [3:0]  enq_wmask;
    logic        sb_full;
    logic        sb_empty;
    logic        ld_valid;
    logic [31:0] ld_addr;
    logic [3:0]  ld_rmask;
    logic        ld_hit;
    logic        ld_conflict;
    logic [31:0] ld_data;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_wmask;
    logic [31:0] dmem_wdata;
    logic        dmem_resp;

    // Store buffer side
    modport slave (
        input  enq_valid, enq_addr, enq_wdata, enq_wmask,
        input  ld_valid, ld_addr, ld_rmask,
        input  dmem_resp,
        output sb_full, sb_empty,
        output ld_hit, ld_conflict, ld_data,
        output dmem_addr, dmem_wmask, dmem_wdata
    );

    // Core / cache side
    modport master (
        output enq_valid, enq_addr, enq_wdata, enq_wmask,
        output ld_valid, ld_addr, ld_rmask,
        output dmem_resp,
        input  sb_full, sb_empty,
        input  ld_hit, ld_conflict, ld_data,
        input  dmem_addr, dmem_wmask, dmem_wdata
    );
endinterface

// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - post-commit store buffer with in-order cache drain and byte-accurate load forwarding
module store_buffer #(
    parameter int SB_DEPTH = 4,
    localparam int SB_PTR_W = $clog2(SB_DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    store_buffer_if.slave bus
);

    typedef struct packed {
        logic [31:0] data;
        logic [29:0] addr;
        logic [3:0]  mask;
        logic        sent_to_cache;
    } sb_info_t;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [SB_PTR_W-1:0] PTR_ONE  = SB_PTR_W'(1);
    localparam logic [SB_PTR_W:0]   CNT_ONE  = (SB_PTR_W+1)'(1);
    localparam logic [SB_PTR_W:0]   CNT_FULL = (SB_PTR_W+1)'(SB_DEPTH);

    sb_info_t              entry_q [SB_DEPTH];
    logic [SB_DEPTH-1:0]   valid_q;
    logic [SB_PTR_W-1:0]   head_q;
    logic [SB_PTR_W-1:0]   tail_q;
    logic [SB_PTR_W:0]     count_q;
    logic [SB_PTR_W:0]     count_d;
    logic [SB_PTR_W:0]     count_after_deq;
    state_t                state_q;
    state_t                state_d;

    logic                  enq_fire;
    logic                  deq;
    logic                  mark_sent;
    logic [SB_PTR_W-1:0]   mark_idx;
    logic [3:0]            dmem_wmask_d;
    logic [31:0]           dmem_wdata_d;

    logic [3:0]            covered;
    logic [31:0]           fwd_data;
    logic [SB_PTR_W-1:0]   fwd_idx;

    logic                  unused_addr_lsbs;
    assign unused_addr_lsbs = ^{bus.enq_addr[1:0], bus.ld_addr[1:0]};

    assign bus.sb_full  = (count_q == CNT_FULL);
    assign bus.sb_empty = (count_q == '0);

    // A full buffer silently drops the enqueue; commit is responsible for never doing that.
    assign enq_fire = bus.enq_valid && !bus.sb_full;

    // Occupancy that remains if the head retires this cycle (including a same-cycle enqueue).
    assign count_after_deq = count_q + (SB_PTR_W+1)'(enq_fire) - CNT_ONE;
    assign count_d         = count_q + (SB_PTR_W+1)'(enq_fire) - (SB_PTR_W+1)'(deq);

    // Drain FSM: decide the next state, when the head retires and which entry is handed to the cache.
    always_comb begin
        state_d      = state_q;
        deq          = 1'b0;
        mark_sent    = 1'b0;
        mark_idx     = head_q;
        dmem_wmask_d = 4'h0;
        dmem_wdata_d = 32'h0;
        case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    state_d   = BUSY;
                    mark_sent = 1'b1;
                end
            end
            BUSY: begin
                if (entry_q[head_q].sent_to_cache) begin
                    dmem_wmask_d = entry_q[head_q].mask;
                    dmem_wdata_d = entry_q[head_q].data;
                end
                if (bus.dmem_resp) begin
                    deq = 1'b1;
                    if (count_after_deq != '0) begin
                        mark_sent = 1'b1;
                        mark_idx  = head_q + PTR_ONE;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.dmem_wmask = dmem_wmask_d;
    assign bus.dmem_wdata = dmem_wdata_d;
    assign bus.dmem_addr  = {entry_q[head_q].addr, 2'b00};

    // Drain FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Entry storage and pointers; the sent flag is applied last so it wins over a same-cycle enqueue write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SB_DEPTH; i++) begin
                entry_q[i] <= '0;
            end
            valid_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (enq_fire) begin
                entry_q[tail_q] <= '{data: bus.enq_wdata, addr: bus.enq_addr[31:2],
                                     mask: bus.enq_wmask, sent_to_cache: 1'b0};
                valid_q[tail_q] <= 1'b1;
                tail_q          <= tail_q + PTR_ONE;
            end
            if (deq) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= head_q + PTR_ONE;
            end
            if (mark_sent) begin
                entry_q[mark_idx].sent_to_cache <= 1'b1;
            end
            count_q <= count_d;
        end
    end

    // Forwarding: walk entries oldest to youngest so the youngest matching lane overwrites older ones.
    always_comb begin
        covered  = 4'h0;
        fwd_data = 32'h0;
        fwd_idx  = head_q;
        for (int k = 0; k < SB_DEPTH; k++) begin
            fwd_idx = head_q + k[SB_PTR_W-1:0];
            if (valid_q[fwd_idx] && (entry_q[fwd_idx].addr == bus.ld_addr[31:2])) begin
                for (int b = 0; b < 4; b++) begin
                    if (entry_q[fwd_idx].mask[b] && bus.ld_rmask[b]) begin
                        covered[b]        = 1'b1;
                        fwd_data[8*b +: 8] = entry_q[fwd_idx].data[8*b +: 8];
                    end
                end
            end
        end
    end

    assign bus.ld_hit      = bus.ld_valid && (bus.ld_rmask != 4'h0) && ((bus.ld_rmask & ~covered) == 4'h0);
    assign bus.ld_conflict = bus.ld_valid && (covered != 4'h0) && !bus.ld_hit;
    assign bus.ld_data     = bus.ld_valid ? fwd_data : 32'h0;

endmodule

// File: tb/tb_store_buffer.sv
// tb/tb_store_buffer.sv - scoreboard bench for store_buffer with a queue-based reference model
module tb_store_buffer;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    store_buffer_if bus();

    store_buffer #(.SB_DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  mask;
    } st_t;

    typedef struct {
        logic        hit;
        logic        conf;
        logic [31:0] data;
    } ld_t;

    st_t m_q[$];
    st_t wr_exp_q[$];
    ld_t ld_exp_q[$];
    bit  m_busy;
    int  n_checks;
    int  n_pass;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // Model load lookup: per lane, the youngest buffered store to that word covering the lane.
    function automatic ld_t model_load(input logic [31:0] la, input logic [3:0] lm);
        ld_t r;
        logic [3:0] cov;
        bit found;
        cov = 4'h0;
        r.data = 32'h0;
        for (int b = 0; b < 4; b++) begin
            found = 0;
            if (lm[b]) begin
                for (int j = m_q.size() - 1; j >= 0; j--) begin
                    if (!found && m_q[j].addr[31:2] == la[31:2] && m_q[j].mask[b]) begin
                        found = 1;
                        cov[b] = 1'b1;
                        r.data[8*b +: 8] = m_q[j].data[8*b +: 8];
                    end
                end
            end
        end
        r.hit  = (lm != 4'h0) && ((lm & ~cov) == 4'h0);
        r.conf = (cov != 4'h0) && !r.hit;
        return r;
    endfunction

    // Advance the model at a clock edge using the inputs that were applied for that cycle.
    task automatic model_edge();
        bit deq, enq;
        int old_size;
        st_t s;
        if (!rst_n) return;
        old_size = m_q.size();
        deq = m_busy && bus.dmem_resp;
        enq = bus.enq_valid && (old_size < DEPTH);
        if (deq) void'(m_q.pop_front());
        if (enq) begin
            s.addr = {bus.enq_addr[31:2], 2'b00};
            s.data = bus.enq_wdata;
            s.mask = bus.enq_wmask;
            m_q.push_back(s);
            wr_exp_q.push_back(s);
        end
        if (m_busy) m_busy = deq ? (m_q.size() != 0) : 1'b1;
        else        m_busy = (old_size != 0);
    endtask

    task automatic cyc(input bit ev, input logic [31:0] ea, input logic [31:0] ed, input logic [3:0] em,
                       input bit rsp, input bit lv, input logic [31:0] la, input logic [3:0] lm);
        bus.enq_valid = ev && (m_q.size() < DEPTH);
        bus.enq_addr  = ea;
        bus.enq_wdata = ed;
        bus.enq_wmask = em;
        bus.dmem_resp = rsp;
        bus.ld_valid  = lv;
        bus.ld_addr   = la;
        bus.ld_rmask  = lm;
        if (lv) ld_exp_q.push_back(model_load(la, lm));
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic enq(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m, input bit rsp);
        cyc(1, a, d, m, rsp, 0, 32'h0, 4'h0);
    endtask

    task automatic idle(input int n, input bit rsp);
        for (int i = 0; i < n; i++) cyc(0, 32'h0, 32'h0, 4'h0, rsp, 0, 32'h0, 4'h0);
    endtask

    task automatic ld_direct(input logic [31:0] la, input logic [3:0] lm,
                             input logic hit, input logic conf, input logic [31:0] data);
        ld_t r;
        r.hit = hit; r.conf = conf; r.data = data;
        bus.enq_valid = 0;
        bus.dmem_resp = 0;
        bus.ld_valid  = 1;
        bus.ld_addr   = la;
        bus.ld_rmask  = lm;
        ld_exp_q.push_back(r);
        @(posedge clk);
        model_edge();
        #1;
        bus.ld_valid = 0;
    endtask

    task automatic do_reset();
        rst_n = 0;
        bus.enq_valid = 0; bus.enq_addr = 0; bus.enq_wdata = 0; bus.enq_wmask = 0;
        bus.ld_valid = 0; bus.ld_addr = 0; bus.ld_rmask = 0; bus.dmem_resp = 0;
        m_q.delete(); wr_exp_q.delete(); ld_exp_q.delete();
        m_busy = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
    endtask

    // Monitor: compares status, the presented cache write and load results against the scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            check("sb_empty", bus.sb_empty, m_q.size() == 0);
            check("sb_full", bus.sb_full, m_q.size() == DEPTH);
            check("write_presented", bus.dmem_wmask != 4'h0, m_busy);
            check("enq_while_full", bus.enq_valid && bus.sb_full, 1'b0);
            if (bus.dmem_wmask != 4'h0) begin
                if (wr_exp_q.size() == 0) fail_now("unexpected_cache_write");
                else begin
                    check("dmem_addr", bus.dmem_addr, wr_exp_q[0].addr);
                    check("dmem_wmask", bus.dmem_wmask, wr_exp_q[0].mask);
                    check("dmem_wdata", bus.dmem_wdata, wr_exp_q[0].data);
                    if (bus.dmem_resp) void'(wr_exp_q.pop_front());
                end
            end else begin
                check("dmem_wdata_idle", bus.dmem_wdata, 32'h0);
            end
            if (bus.ld_valid) begin
                if (ld_exp_q.size() == 0) fail_now("unexpected_load");
                else begin
                    ld_t e;
                    e = ld_exp_q.pop_front();
                    check("ld_hit", bus.ld_hit, e.hit);
                    check("ld_conflict", bus.ld_conflict, e.conf);
                    check("ld_data", bus.ld_data, e.data);
                end
            end
        end
    end

    initial begin
        n_checks = 0;
        n_pass = 0;
        do_reset();

        // Reset values
        @(negedge clk);
        check("rst_sb_empty", bus.sb_empty, 1'b1);
        check("rst_sb_full", bus.sb_full, 1'b0);
        check("rst_dmem_wmask", bus.dmem_wmask, 4'h0);
        check("rst_dmem_wdata", bus.dmem_wdata, 32'h0);
        check("rst_dmem_addr", bus.dmem_addr, 32'h0);
        check("rst_ld_hit", bus.ld_hit, 1'b0);
        check("rst_ld_conflict", bus.ld_conflict, 1'b0);
        check("rst_ld_data", bus.ld_data, 32'h0);
        @(posedge clk);
        #1;

        // Reset while a write is in flight with three entries buffered
        enq(32'h100, 32'h1111_1111, 4'hF, 0);
        enq(32'h104, 32'h2222_2222, 4'hF, 0);
        enq(32'h108, 32'h3333_3333, 4'hF, 0);
        idle(2, 0);
        check("pre_reset_busy", bus.dmem_wmask, 4'hF);
        do_reset();
        idle(2, 1);
        #3;
        check("post_reset_empty", bus.sb_empty, 1'b1);
        check("post_reset_wmask", bus.dmem_wmask, 4'h0);

        // Single word store, response three cycles after the request appears
        enq(32'h1000, 32'hDEAD_BEEF, 4'hF, 0);
        idle(4, 0);
        idle(1, 1);
        idle(1, 0);
        #3;
        check("sw_done_empty", bus.sb_empty, 1'b1);
        check("sw_done_wmask", bus.dmem_wmask, 4'h0);

        // Fill to full, steady-state enqueue+dequeue, then drain across the pointer wrap
        for (int i = 0; i < 4; i++) enq(32'h10 + 32'(i * 4), 32'hA000_0000 + 32'(i), 4'hF, 0);
        #3;
        check("fill_full", bus.sb_full, 1'b1);
        idle(1, 1);
        for (int i = 0; i < 7; i++) enq(32'h20 + 32'(i * 4), 32'hB000_0000 + 32'(i), 4'hF, 1);
        #3;
        check("steady_not_full", bus.sb_full, 1'b0);
        idle(6, 1);
        #3;
        check("wrap_drained", bus.sb_empty, 1'b1);

        // Youngest store wins on the same lane
        enq(32'h2000, 32'h0000_00AA, 4'h1, 0);
        enq(32'h2000, 32'h0000_00BB, 4'h1, 0);
        ld_direct(32'h2000, 4'h1, 1'b1, 1'b0, 32'h0000_00BB);
        idle(6, 1);

        // Partial coverage forces a retry; a different word goes to the cache
        enq(32'h3000, 32'h0000_1234, 4'h3, 0);
        ld_direct(32'h3000, 4'hF, 1'b0, 1'b1, 32'h0000_1234);
        ld_direct(32'h3004, 4'hF, 1'b0, 1'b0, 32'h0000_0000);
        idle(4, 1);

        // Lanes merged from three stores, oldest already in flight
        enq(32'h4000, 32'h1100_0000, 4'h8, 0);
        enq(32'h4000, 32'h0000_5566, 4'h3, 0);
        enq(32'h4000, 32'h0022_0000, 4'h4, 0);
        ld_direct(32'h4000, 4'hF, 1'b1, 1'b0, 32'h1122_5566);
        idle(1, 0);
        ld_direct(32'h4000, 4'hF, 1'b1, 1'b0, 32'h1122_5566);
        idle(6, 1);

        // Random traffic against the reference model
        for (int i = 0; i < 1500; i++) begin
            logic [31:0] ea, la;
            ea = 32'h5000 + 32'($urandom_range(0, 3) * 4) + 32'($urandom_range(0, 3));
            la = 32'h5000 + 32'($urandom_range(0, 4) * 4) + 32'($urandom_range(0, 3));
            cyc($urandom_range(0, 1), ea, $urandom, 4'($urandom_range(1, 15)),
                ($urandom_range(0, 2) != 0), $urandom_range(0, 1), la, 4'($urandom_range(0, 15)));
        end
        idle(12, 1);

        check("wr_queue_drained", wr_exp_q.size(), 0);
        check("ld_queue_drained", ld_exp_q.size(), 0);
        check("final_empty", bus.sb_empty, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
